// File: rtl/gain_nvoies_pkg.sv
// Shared constants, types and helpers for the gain_nvoies AXI4-Lite peripheral.
package gain_nvoies_pkg;

  localparam int unsigned ADDR_CTRL   = 32'h00;
  localparam int unsigned ADDR_STATUS = 32'h04;
  localparam int unsigned ADDR_GAIN0  = 32'h08;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_SAT    = 1;
  localparam logic [1:0] CTRL_RESET = 2'b11;

  localparam int STATUS_BAD_BIT = 31;
  localparam int USER_W         = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {MODE_SCALE, MODE_PASS, MODE_ZERO} mac_mode_e;
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic logic is_gain_addr(input int unsigned addr, input int unsigned n_ch);
    return (addr >= ADDR_GAIN0) && (addr < ADDR_GAIN0 + 4 * n_ch) && ((addr % 4) == 0);
  endfunction

  // Byte-lane merge: lanes with a strobe take new_w, the rest keep old_w.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
    return (old_w & ~m) | (new_w & m);
  endfunction

endpackage

// File: rtl/gain_nvoies_axil_if.sv
// AXI4-Lite bus bundle; PROT is not carried because the peripheral ignores it.
interface gain_nvoies_axil_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/gain_nvoies_mac.sv
// Two-stage multiply / round / saturate pipeline; both stages shift only on adv.
module gain_nvoies_mac
  import gain_nvoies_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 16,
  parameter int FRAC   = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [GAIN_W-1:0] in_gain,
  input  logic [USER_W-1:0]        in_user,
  input  mac_mode_e                in_mode,
  input  logic                     in_sat,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [USER_W-1:0]        out_user,
  output logic                     ovf,
  output logic [USER_W-1:0]        ovf_user
);

  localparam int PW = DATA_W + GAIN_W;
  localparam logic signed [PW:0] RND   = (PW+1)'(2 ** (FRAC - 1));
  localparam logic signed [PW:0] Y_MAX = (PW+1)'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [PW:0] Y_MIN = ~Y_MAX;

  logic                 s1_valid;
  logic signed [PW-1:0] s1_prod;
  logic [USER_W-1:0]    s1_user;
  mac_mode_e            s1_mode;
  logic                 s1_sat;

  logic signed [PW-1:0] prod_c;
  logic signed [PW:0]   sum_ext;
  logic signed [PW:0]   shifted;
  logic                 too_big;
  logic                 too_small;
  logic [DATA_W-1:0]    y;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    prod_c = '0;
    case (in_mode)
      MODE_SCALE: prod_c = PW'(in_data) * PW'(in_gain);
      MODE_PASS:  prod_c = PW'(in_data);
      default:    prod_c = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so both stages see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_user  <= '0;
      s1_mode  <= MODE_ZERO;
      s1_sat   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_prod  <= prod_c;
      s1_user  <= in_user;
      s1_mode  <= in_mode;
      s1_sat   <= in_sat;
    end
  end

  always_comb begin
    sum_ext   = (PW+1)'(s1_prod) + RND;
    shifted   = sum_ext >>> FRAC;
    too_big   = shifted > Y_MAX;
    too_small = shifted < Y_MIN;
    y         = '0;
    case (s1_mode)
      MODE_SCALE: begin
        if (s1_sat && too_big)        y = Y_MAX[DATA_W-1:0];
        else if (s1_sat && too_small) y = Y_MIN[DATA_W-1:0];
        else                          y = shifted[DATA_W-1:0];
      end
      MODE_PASS: y = s1_prod[DATA_W-1:0];
      default:   y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      out_data  <= y;
      out_user  <= s1_user;
    end
  end

  // Flag fires on the edge the out-of-range result moves into stage 2.
  assign ovf      = adv && s1_valid && (s1_mode == MODE_SCALE) && (too_big || too_small);
  assign ovf_user = s1_user;

endmodule

// File: rtl/gain_nvoies_axil.sv
// Per-channel gain peripheral: AXI4-Lite register file plus a scaled TDM sample stream.
module gain_nvoies_axil
  import gain_nvoies_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int GAIN_W = 16,
  parameter int FRAC   = 12
) (
  input  logic                ACLK,
  input  logic                ARESET,
  gain_nvoies_axil_if.slave   s_axi,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [USER_W-1:0]   s_tuser,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [USER_W-1:0]   m_tuser
);

  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(2 ** FRAC);

  logic [1:0]        ctrl;
  logic [GAIN_W-1:0] gain [N_CH];
  logic [N_CH-1:0]   ovf_flags;
  logic              bad_flag;

  wr_state_e w_state;
  rd_state_e r_state;

  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [C_S_AXI_ADDR_WIDTH-1:0] rd_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  int unsigned wa;
  int unsigned ra;
  logic        wr_fire;
  logic        wr_mapped;
  logic        rd_mapped;
  logic [31:0] clr_mask;

  assign wr_addr   = s_axi.awaddr;
  assign rd_addr   = s_axi.araddr;
  assign wa        = 32'(wr_addr);
  assign ra        = 32'(rd_addr);
  assign wr_mapped = (wa == ADDR_CTRL) || (wa == ADDR_STATUS) || is_gain_addr(wa, N_CH);
  assign wr_fire   = (w_state == W_IDLE) && s_axi.awready && s_axi.awvalid && s_axi.wvalid;
  assign clr_mask  = (wr_fire && (wa == ADDR_STATUS)) ? strb_merge('0, s_axi.wdata, s_axi.wstrb) : '0;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state       <= W_IDLE;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi.awready) begin
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            if (s_axi.awvalid && s_axi.wvalid) begin
              s_axi.bvalid <= 1'b1;
              s_axi.bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
              w_state      <= W_RESP;
            end
          end else if (s_axi.awvalid && s_axi.wvalid) begin
            s_axi.awready <= 1'b1;
            s_axi.wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            s_axi.bvalid <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the gain table is a few flops rather than a RAM, so it is reset to unity like any other register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl <= CTRL_RESET;
      for (int k = 0; k < N_CH; k++) gain[k] <= GAIN_UNITY;
    end else if (wr_fire) begin
      if (wa == ADDR_CTRL) ctrl <= 2'(strb_merge(32'(ctrl), s_axi.wdata, s_axi.wstrb));
      for (int k = 0; k < N_CH; k++)
        if (wa == ADDR_GAIN0 + 4 * k)
          gain[k] <= GAIN_W'(strb_merge(32'(gain[k]), s_axi.wdata, s_axi.wstrb));
    end
  end

  // Stream side: both pipeline stages advance together under adv.
  logic              adv;
  logic              ch_bad;
  logic [GAIN_W-1:0] g_sel;
  mac_mode_e         mode_sel;
  logic              mac_ovf;
  logic [USER_W-1:0] mac_ovf_user;
  logic [N_CH-1:0]   ovf_set;
  logic              bad_set;

  assign adv      = !m_tvalid || m_tready;
  assign s_tready = adv;
  assign ch_bad   = 32'(s_tuser) >= N_CH;
  assign mode_sel = ch_bad ? MODE_ZERO : (ctrl[CTRL_ENABLE] ? MODE_SCALE : MODE_PASS);
  assign bad_set  = s_tvalid && adv && ch_bad;

  always_comb begin
    g_sel   = '0;
    ovf_set = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (s_tuser == USER_W'(k)) g_sel = gain[k];
      ovf_set[k] = mac_ovf && (mac_ovf_user == USER_W'(k));
    end
  end

  gain_nvoies_mac #(
    .DATA_W (DATA_W),
    .GAIN_W (GAIN_W),
    .FRAC   (FRAC)
  ) u_mac (
    .clk       (ACLK),
    .rst       (ARESET),
    .adv       (adv),
    .in_valid  (s_tvalid),
    .in_data   (signed'(s_tdata)),
    .in_gain   (signed'(g_sel)),
    .in_user   (s_tuser),
    .in_mode   (mode_sel),
    .in_sat    (ctrl[CTRL_SAT]),
    .out_valid (m_tvalid),
    .out_data  (m_tdata),
    .out_user  (m_tuser),
    .ovf       (mac_ovf),
    .ovf_user  (mac_ovf_user)
  );

  // A set in the same cycle as a W1C clear of the same bit wins.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ovf_flags <= '0;
      bad_flag  <= 1'b0;
    end else begin
      ovf_flags <= (ovf_flags & ~clr_mask[N_CH-1:0]) | ovf_set;
      bad_flag  <= (bad_flag & ~clr_mask[STATUS_BAD_BIT]) | bad_set;
    end
  end

  always_comb begin
    rd_word   = '0;
    rd_mapped = 1'b1;
    if (ra == ADDR_CTRL) begin
      rd_word[1:0] = ctrl;
    end else if (ra == ADDR_STATUS) begin
      rd_word[N_CH-1:0]      = ovf_flags;
      rd_word[STATUS_BAD_BIT] = bad_flag;
    end else if (is_gain_addr(ra, N_CH)) begin
      for (int k = 0; k < N_CH; k++)
        if (ra == ADDR_GAIN0 + 4 * k) rd_word[GAIN_W-1:0] = gain[k];
    end else begin
      rd_mapped = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state       <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi.arready) begin
            s_axi.arready <= 1'b0;
            if (s_axi.arvalid) begin
              s_axi.rvalid <= 1'b1;
              s_axi.rdata  <= rd_word;
              s_axi.rresp  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
              r_state      <= R_DATA;
            end
          end else if (s_axi.arvalid) begin
            s_axi.arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            s_axi.rvalid <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
